mixer_nch: RTL
==============

// Module: mixer_nch
// PURPOSE
//  Parametrised N-channel PCM sound mixer with per-channel volume and L/R routing.
//  It replaces the fixed-input mixer: beeper, AY, TurboSound and Soundrive all feed one generic channel bus.
//  Channels are time-multiplexed into one accumulator, saturated, then fed to first-order sigma-delta DACs (snd_l/snd_r pins).
// PARAMETERS
//  CHANNELS  8  number of input channels (>=1)
//  SAMPLE_W  8  unsigned sample width per channel
//  VOL_W     4  unsigned volume width per channel (0 = mute)
//  OUT_W    12  PCM width presented to the DACs
//  SHIFT     3  right shift applied to the accumulator before saturation
// PORTS
//  clk28       in   1                    system clock, 28 MHz
//  rst         in   1                    asynchronous reset, active-high
//  sample_stb  in   1                    start one mix pass (single-cycle pulse)
//  ch_data     in   CHANNELS*SAMPLE_W    channel samples; channel i = [i*SAMPLE_W +: SAMPLE_W]
//  ch_vol      in   CHANNELS*VOL_W       per-channel volume
//  ch_pan      in   CHANNELS*2           bit0 = route to L, bit1 = route to R
//  mono        in   1                    1: route every channel with pan!=0 to both sides
//  busy        out  1                    mix pass in progress
//  pcm_l       out  OUT_W                mixed left sample
//  pcm_r       out  OUT_W                mixed right sample
//  pcm_valid   out  1                    1-cycle pulse when pcm_l/pcm_r update
//  dac_l       out  1                    sigma-delta bitstream, left
//  dac_r       out  1                    sigma-delta bitstream, right
// BEHAVIOUR
//  Reset: all outputs 0; accumulators, sigma-delta integrators and FSM (IDLE) cleared. Reset wins over everything.
//  FSM IDLE -> MIX -> OUT -> IDLE.
//   - IDLE: on sample_stb at cycle T, snapshot ch_data, ch_vol, ch_pan and mono; clear acc_l/acc_r; enter MIX.
//   - MIX: on cycles T+1..T+CHANNELS, process channel idx (0 first).
//     - prod = data*vol (SAMPLE_W+VOL_W bits, unsigned).
//     - acc_l += pan[0]|(mono&pan[1]) ? prod : 0; acc_r likewise, mirrored.
//   - OUT: at cycle T+CHANNELS+1, pcm_x <= min(acc_x>>SHIFT, 2^OUT_W-1); pcm_valid=1 for this cycle only; next state IDLE.
//  Accumulator width = SAMPLE_W+VOL_W+clog2(CHANNELS)+1; it never wraps.
//  busy = 1 from T+1 through T+CHANNELS+1 inclusive.
//  sample_stb is ignored while busy, with no queuing. A strobe in the same cycle as the OUT state is also ignored.
//  Changes to ch_* inputs after the snapshot do not affect the pass in flight.
//  DAC (every clk28, independent of FSM): {dac_x, sd_x} <= {1'b0, sd_x} + pcm_x (OUT_W-bit integrator, carry = output bit).
//  pcm_x = 0 gives a constant 0. Ones density = pcm_x / 2^OUT_W.
//  Reset mid-pass: pass aborted, no pcm_valid, pcm_x = 0.
// CONFIGURATION
//  MIXER_PEAK_EN defined: adds peak_clr (in, 1), peak_l and peak_r (out, OUT_W).
//   - In OUT state, peak_x <= max(peak_x, new pcm_x).
//   - peak_clr zeroes peak_x. If peak_clr coincides with OUT, peak_x = new pcm_x.
//   - Reset clears both peaks.
//  MIXER_PEAK_EN undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING (defaults unless stated)
//  1. Reset asserted mid-simulation -> busy=0, pcm_l=pcm_r=0, dac_l=dac_r=0, pcm_valid=0.
//  2. ch0=0xFF, vol0=15, pan0=01, all other channels vol=0; strobe at T.
//     -> pcm_valid at T+9 only; pcm_l=478, pcm_r=0; busy high T+1..T+9.
//  3. All channels 0xFF, vol=15, pan=11 -> pcm_l=pcm_r=3825.
//     Same stimulus with SHIFT=2 -> both saturate to 4095.
//  4. Second strobe at T+4, ch_data changed at T+2 -> exactly one pcm_valid (T+9); result uses the T snapshot.
//  5. pcm_l held at 2048 -> dac_l ones density 50% over 64 cycles. pcm_r=0 -> dac_r stays 0.
//  6. mono=1, ch0 pan=10, other settings as test 2 -> pcm_l=pcm_r=478.
//     With MIXER_PEAK_EN: peak_l=478 after the pass; peak_clr pulse -> 0.

Source files
------------

// File: rtl/mixer_nch.sv
// N-channel time-multiplexed PCM mixer with per-channel volume, L/R routing and sigma-delta DACs.
// Optional peak meters are compiled in with `define MIXER_PEAK_EN.
module mixer_nch #(
   parameter int CHANNELS = 8,
   parameter int SAMPLE_W = 8,
   parameter int VOL_W    = 4,
   parameter int OUT_W    = 12,
   parameter int SHIFT    = 3
) (
   input  logic                         clk28,
   input  logic                         rst,
   input  logic                         sample_stb,
   input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
   input  logic [CHANNELS*VOL_W-1:0]    ch_vol,
   input  logic [CHANNELS*2-1:0]        ch_pan,
   input  logic                         mono,
`ifdef MIXER_PEAK_EN
   input  logic                         peak_clr,
   output logic [OUT_W-1:0]             peak_l,
   output logic [OUT_W-1:0]             peak_r,
`endif
   output logic                         busy,
   output logic [OUT_W-1:0]             pcm_l,
   output logic [OUT_W-1:0]             pcm_r,
   output logic                         pcm_valid,
   output logic                         dac_l,
   output logic                         dac_r
);

   localparam int PROD_W = SAMPLE_W + VOL_W;
   localparam int ACC_W  = PROD_W + $clog2(CHANNELS) + 1;
   localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
   localparam logic [SAT_W-1:0] OUT_MAX  = SAT_W'({OUT_W{1'b1}});

   typedef enum logic [1:0] {IDLE, MIX, OUT} state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [CHANNELS*SAMPLE_W-1:0] data_q, data_d;
   logic [CHANNELS*VOL_W-1:0]    vol_q, vol_d;
   logic [CHANNELS*2-1:0]        pan_q, pan_d;
   logic                         mono_q, mono_d;
   logic [ACC_W-1:0]             acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [OUT_W-1:0]             pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
   logic [OUT_W-1:0]             sd_l_q, sd_r_q;
   logic                         dac_l_q, dac_r_q;

   logic [SAMPLE_W-1:0]          cur_data;
   logic [VOL_W-1:0]             cur_vol;
   logic [1:0]                   cur_pan;
   logic [PROD_W-1:0]            prod;
   logic                         route_l, route_r;

   function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] acc);
      logic [SAT_W-1:0] s;
      s = SAT_W'(acc) >> SHIFT;
      return (s > OUT_MAX) ? '1 : s[OUT_W-1:0];
   endfunction

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      data_d   = data_q;
      vol_d    = vol_q;
      pan_d    = pan_q;
      mono_d   = mono_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      pcm_l_d  = pcm_l_q;
      pcm_r_d  = pcm_r_q;
      cur_data = data_q[idx_q*SAMPLE_W +: SAMPLE_W];
      cur_vol  = vol_q[idx_q*VOL_W +: VOL_W];
      cur_pan  = pan_q[idx_q*2 +: 2];
      prod     = PROD_W'(cur_data) * PROD_W'(cur_vol);
      route_l  = cur_pan[0] | (mono_q & cur_pan[1]);
      route_r  = cur_pan[1] | (mono_q & cur_pan[0]);
      case (state_q)
         IDLE: begin
            if (sample_stb) begin
               data_d  = ch_data;
               vol_d   = ch_vol;
               pan_d   = ch_pan;
               mono_d  = mono;
               acc_l_d = '0;
               acc_r_d = '0;
               idx_d   = '0;
               state_d = MIX;
            end
         end
         MIX: begin
            acc_l_d = acc_l_q + (route_l ? ACC_W'(prod) : '0);
            acc_r_d = acc_r_q + (route_r ? ACC_W'(prod) : '0);
            // PCM loads on the edge into OUT so it is already valid while pcm_valid is high
            if (idx_q == LAST_IDX) begin
               pcm_l_d = saturate(acc_l_d);
               pcm_r_d = saturate(acc_r_d);
               state_d = OUT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         vol_q   <= '0;
         pan_q   <= '0;
         mono_q  <= 1'b0;
         acc_l_q <= '0;
         acc_r_q <= '0;
         pcm_l_q <= '0;
         pcm_r_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         vol_q   <= vol_d;
         pan_q   <= pan_d;
         mono_q  <= mono_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
         pcm_l_q <= pcm_l_d;
         pcm_r_q <= pcm_r_d;
      end
   end

   // First-order sigma-delta: the integrator carry is the output bit
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         sd_l_q  <= '0;
         sd_r_q  <= '0;
         dac_l_q <= 1'b0;
         dac_r_q <= 1'b0;
      end else begin
         {dac_l_q, sd_l_q} <= {1'b0, sd_l_q} + {1'b0, pcm_l_q};
         {dac_r_q, sd_r_q} <= {1'b0, sd_r_q} + {1'b0, pcm_r_q};
      end
   end

`ifdef MIXER_PEAK_EN
   logic [OUT_W-1:0] peak_l_q, peak_r_q;

   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         peak_l_q <= '0;
         peak_r_q <= '0;
      end else if (state_q == OUT) begin
         peak_l_q <= (peak_clr || pcm_l_q > peak_l_q) ? pcm_l_q : peak_l_q;
         peak_r_q <= (peak_clr || pcm_r_q > peak_r_q) ? pcm_r_q : peak_r_q;
      end else if (peak_clr) begin
         peak_l_q <= '0;
         peak_r_q <= '0;
      end
   end

   assign peak_l = peak_l_q;
   assign peak_r = peak_r_q;
`endif

   assign busy      = (state_q != IDLE);
   assign pcm_valid = (state_q == OUT);
   assign pcm_l     = pcm_l_q;
   assign pcm_r     = pcm_r_q;
   assign dac_l     = dac_l_q;
   assign dac_r     = dac_r_q;

endmodule
